// File: rtl/aes_output_buffer.sv
// Output buffer behind the AES decryption pipeline: DEPTH-block FIFO plus a 128->4x32 serializer.
// Optional `AES_OUTBUF_CNT_EN adds block/stall counters (o_block_cnt, o_stall_cnt).
module aes_output_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_flush,
   input  logic [127:0]                   i_data_output,
   input  logic                           i_data_done,
   output logic                           o_is_full,
   output logic [31:0]                    o_word,
   output logic                           o_word_valid,
   input  logic                           i_word_ready,
   output logic                           o_word_last,
   output logic                           o_empty,
   output logic [$clog2(DEPTH+1)-1:0]     o_level
`ifdef AES_OUTBUF_CNT_EN
   ,
   output logic [15:0]                    o_block_cnt,
   output logic [15:0]                    o_stall_cnt
`endif
);

   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   logic [127:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic [0:0]    r_state;
   logic [1:0]    r_idx;
   logic [127:0]  r_shreg;

   logic          w_push;
   logic          w_accept;
   logic          w_last_accept;
   logic          w_pop;
   logic [31:0]   w_word;

   assign o_is_full     = (r_level == LW'(DEPTH));
   assign w_push        = i_data_done & ~o_is_full;
   assign w_accept      = (r_state == S_SEND) & i_word_ready;
   assign w_last_accept = w_accept & (r_idx == 2'd3);
   // A pop either starts the serializer from idle or chains the next block with no bubble.
   assign w_pop         = (r_level != '0) & ((r_state == S_IDLE) | w_last_accept);

   always_comb begin
      w_word = r_shreg[127:96];
      case (r_idx)
         2'd0:    w_word = r_shreg[127:96];
         2'd1:    w_word = r_shreg[95:64];
         2'd2:    w_word = r_shreg[63:32];
         default: w_word = r_shreg[31:0];
      endcase
   end

   assign o_word_valid = (r_state == S_SEND);
   assign o_word       = o_word_valid ? w_word : 32'd0;
   assign o_word_last  = o_word_valid & (r_idx == 2'd3);
   assign o_empty      = (r_level == '0) & (r_state == S_IDLE);
   assign o_level      = r_level;

   always_ff @(posedge clk) begin
      if (w_push & ~i_flush) begin
         r_mem[r_wr_ptr] <= i_data_output;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_state  <= S_IDLE;
         r_idx    <= 2'd0;
         r_shreg  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_state  <= S_IDLE;
         r_idx    <= 2'd0;
         r_shreg  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push & ~w_pop) begin
            r_level <= r_level + 1'b1;
         end else if (~w_push & w_pop) begin
            r_level <= r_level - 1'b1;
         end
         if (w_pop) begin
            r_shreg <= r_mem[r_rd_ptr];
            r_idx   <= 2'd0;
            r_state <= S_SEND;
         end else if (w_accept) begin
            if (r_idx == 2'd3) begin
               r_state <= S_IDLE;
            end else begin
               r_idx <= r_idx + 2'd1;
            end
         end
      end
   end

`ifdef AES_OUTBUF_CNT_EN
   logic [15:0] r_block_cnt;
   logic [15:0] r_stall_cnt;

   // Block count wraps naturally; stall count saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_block_cnt <= 16'd0;
         r_stall_cnt <= 16'd0;
      end else if (i_flush) begin
         r_block_cnt <= 16'd0;
         r_stall_cnt <= 16'd0;
      end else begin
         if (w_last_accept) begin
            r_block_cnt <= r_block_cnt + 16'd1;
         end
         if (o_is_full & i_data_done & (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   assign o_block_cnt = r_block_cnt;
   assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_aes_output_buffer.sv
// Directed self-checking bench for aes_output_buffer (DEPTH=4); counter checks when AES_OUTBUF_CNT_EN is set.
module tb_aes_output_buffer;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_flush;
   logic [127:0] i_data_output;
   logic         i_data_done;
   logic         i_word_ready;
   logic         o_is_full;
   logic [31:0]  o_word;
   logic         o_word_valid;
   logic         o_word_last;
   logic         o_empty;
   logic [2:0]   o_level;
`ifdef AES_OUTBUF_CNT_EN
   logic [15:0]  o_block_cnt;
   logic [15:0]  o_stall_cnt;
`endif

   int n_checks = 0;
   int n_err    = 0;
   bit rand_mode = 1'b0;

   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   logic        last_q[$];

   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b0;
   logic [31:0] prev_word  = 32'd0;

   aes_output_buffer #(.DEPTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_flush       (i_flush),
      .i_data_output (i_data_output),
      .i_data_done   (i_data_done),
      .o_is_full     (o_is_full),
      .o_word        (o_word),
      .o_word_valid  (o_word_valid),
      .i_word_ready  (i_word_ready),
      .o_word_last   (o_word_last),
      .o_empty       (o_empty),
      .o_level       (o_level)
`ifdef AES_OUTBUF_CNT_EN
      ,
      .o_block_cnt   (o_block_cnt),
      .o_stall_cnt   (o_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accepted-word capture, stability while stalled, and level bound (push-when-full guard).
   always @(negedge clk) begin
      if (!rst) begin
         if (o_word_valid && i_word_ready) begin
            got_q.push_back(o_word);
            last_q.push_back(o_word_last);
         end
         if (prev_valid && !prev_ready && o_word_valid) begin
            check("word_stable", 128'(o_word), 128'(prev_word));
         end
         check("level_le_depth", 128'(o_level <= 3'd4), 128'(1));
      end
      prev_valid = o_word_valid & !rst;
      prev_ready = i_word_ready;
      prev_word  = o_word;
   end

   always @(posedge clk) begin
      if (rand_mode) begin
         #1 i_word_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic push_block(input logic [127:0] blk);
      int n = 0;
      bit taken = 1'b0;
      i_data_output = blk;
      i_data_done   = 1'b1;
      while (!taken && n < 300) begin
         @(negedge clk);
         if (!o_is_full) taken = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      i_data_done = 1'b0;
      if (!taken) check("push_timeout", 128'(0), 128'(1));
      exp_q.push_back(blk[127:96]);
      exp_q.push_back(blk[95:64]);
      exp_q.push_back(blk[63:32]);
      exp_q.push_back(blk[31:0]);
   endtask

   task automatic wait_empty();
      int n = 0;
      while (!o_empty && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check("empty_timeout", 128'(o_empty), 128'(1));
   endtask

   task automatic check_stream(input string tag);
      check({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check(tag, 128'(got_q[i]), 128'(exp_q[i]));
         check({tag, "_last"}, 128'(last_q[i]), 128'(i % 4 == 3));
      end
      got_q.delete();
      exp_q.delete();
      last_q.delete();
   endtask

   initial begin
      logic [127:0] blk;
      logic [127:0] blk_b;
      rst = 1'b1; i_flush = 1'b0; i_data_done = 1'b0; i_word_ready = 1'b0; i_data_output = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset values
      check("rst_valid", 128'(o_word_valid), 128'(0));
      check("rst_empty", 128'(o_empty), 128'(1));
      check("rst_full",  128'(o_is_full), 128'(0));
      check("rst_level", 128'(o_level), 128'(0));
      check("rst_word",  128'(o_word), 128'(0));
      check("rst_last",  128'(o_word_last), 128'(0));

      // Single block, ready held high
      i_word_ready = 1'b1;
      push_block(128'h00112233_44556677_8899AABB_CCDDEEFF);
      @(posedge clk); #1;
      check("t1_w0_valid", 128'(o_word_valid), 128'(1));
      check("t1_w0", 128'(o_word), 128'(32'h00112233));
      check("t1_w0_last", 128'(o_word_last), 128'(0));
      @(posedge clk); #1;
      check("t1_w1", 128'(o_word), 128'(32'h44556677));
      @(posedge clk); #1;
      check("t1_w2", 128'(o_word), 128'(32'h8899AABB));
      check("t1_w2_last", 128'(o_word_last), 128'(0));
      @(posedge clk); #1;
      check("t1_w3", 128'(o_word), 128'(32'hCCDDEEFF));
      check("t1_w3_last", 128'(o_word_last), 128'(1));
      @(posedge clk); #1;
      check("t1_done_valid", 128'(o_word_valid), 128'(0));
      check("t1_done_empty", 128'(o_empty), 128'(1));
      check_stream("t1_stream");

      // Fill with ready low: one block in serializer plus four queued
      i_word_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push_block({4{32'hA0000000 + 32'(i)}});
      end
      check("t2_level", 128'(o_level), 128'(4));
      check("t2_full", 128'(o_is_full), 128'(1));
      check("t2_head", 128'(o_word), 128'(32'hA0000000));
      i_data_output = {4{32'hB5B5B5B5}};
      i_data_done   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("t2_stall_full", 128'(o_is_full), 128'(1));
         check("t2_stall_level", 128'(o_level), 128'(4));
      end
      i_word_ready = 1'b1;
      push_block({4{32'hB5B5B5B5}});
      wait_empty();
      check_stream("t2_stream");

      // Random ready over 20 blocks
      rand_mode = 1'b1;
      for (int i = 0; i < 20; i++) begin
         blk = {$urandom(), $urandom(), $urandom(), $urandom()};
         push_block(blk);
      end
      rand_mode = 1'b0;
      @(posedge clk); #2;
      i_word_ready = 1'b1;
      wait_empty();
      check_stream("t3_stream");

      // Back-to-back drain of three queued blocks
      i_word_ready = 1'b0;
      push_block(128'h11111111_22222222_33333333_44444444);
      push_block(128'h55555555_66666666_77777777_88888888);
      push_block(128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC);
      check("t4_level", 128'(o_level), 128'(2));
      i_word_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         check("t4_no_bubble", 128'(o_word_valid), 128'(1));
         @(posedge clk); #1;
      end
      check("t4_end_valid", 128'(o_word_valid), 128'(0));
      check("t4_end_empty", 128'(o_empty), 128'(1));
      check_stream("t4_stream");

      // Flush during the 2nd word while a new block is presented
      blk_b = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
      push_block(blk_b);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t5_word1", 128'(o_word), 128'(32'hCAFEF00D));
      i_flush = 1'b1;
      i_data_done = 1'b1;
      i_data_output = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
      @(posedge clk); #1;
      i_flush = 1'b0;
      i_data_done = 1'b0;
      check("t5_valid", 128'(o_word_valid), 128'(0));
      check("t5_level", 128'(o_level), 128'(0));
      check("t5_empty", 128'(o_empty), 128'(1));
      repeat (5) @(posedge clk);
      #1;
      check("t5_still_empty", 128'(o_empty), 128'(1));
      exp_q = exp_q[0:1];
      check_stream("t5_stream");

`ifdef AES_OUTBUF_CNT_EN
      check("c_block_after_flush", 128'(o_block_cnt), 128'(0));
      for (int i = 0; i < 3; i++) begin
         push_block({4{32'hC0DE0000 + 32'(i)}});
      end
      wait_empty();
      check("c_block_cnt", 128'(o_block_cnt), 128'(3));
      check_stream("c_stream");
      i_word_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push_block({4{32'hD0000000 + 32'(i)}});
      end
      check("c_stall_pre", 128'(o_stall_cnt), 128'(0));
      i_data_done = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      i_data_done = 1'b0;
      check("c_stall_cnt", 128'(o_stall_cnt), 128'(7));
`else
      i_word_ready = 1'b0;
      push_block(128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C);
      @(posedge clk); #1;
`endif

      // Asynchronous reset mid-word
      check("r_pre_valid", 128'(o_word_valid), 128'(1));
      #2 rst = 1'b1;
      #1;
      check("r_async_valid", 128'(o_word_valid), 128'(0));
      check("r_async_empty", 128'(o_empty), 128'(1));
      check("r_async_level", 128'(o_level), 128'(0));
`ifdef AES_OUTBUF_CNT_EN
      check("r_async_block", 128'(o_block_cnt), 128'(0));
      check("r_async_stall", 128'(o_stall_cnt), 128'(0));
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      got_q.delete();
      exp_q.delete();
      last_q.delete();
      @(posedge clk); #1;
      check("r_post_valid", 128'(o_word_valid), 128'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
